// File: rtl/ndata_axi_typed_packer.sv
// Packs an ndata stream of typed elements (8/16/32/64 bit) into a
// 64*NUM_ELEMENTS-bit AXI4-Stream, one output beat per 64/w input beats.
module ndata_axi_typed_packer #(
   parameter  int NUM_ELEMENTS   = 8,
   parameter  int MIN_TYPE_WIDTH = 8,
   localparam int AXI_WIDTH      = 64 * NUM_ELEMENTS,
   localparam int KEEP_WIDTH     = AXI_WIDTH / 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [7:0]                   actual_type_data,
   input  logic                         actual_type_valid,
   output logic                         actual_type_ready,
   input  logic [NUM_ELEMENTS-1:0][63:0] in_data,
   input  logic [NUM_ELEMENTS-1:0]      in_keep,
   input  logic                         in_last,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [AXI_WIDTH-1:0]         out_tdata,
   output logic [KEEP_WIDTH-1:0]        out_tkeep,
   output logic                         out_tlast,
   output logic                         out_tvalid,
   input  logic                         out_tready,
   output logic                         type_error
);

   localparam logic [7:0] MIN_W = 8'(MIN_TYPE_WIDTH);

   logic [2:0]            slot_q, slot_d;
   logic [AXI_WIDTH-1:0]  fill_data_q, fill_data_d;
   logic [KEEP_WIDTH-1:0] fill_keep_q, fill_keep_d;
   logic [AXI_WIDTH-1:0]  out_tdata_q, out_tdata_d;
   logic [KEEP_WIDTH-1:0] out_tkeep_q, out_tkeep_d;
   logic                  out_tlast_q, out_tlast_d;
   logic                  out_tvalid_q, out_tvalid_d;
   logic                  type_error_q, type_error_d;

   logic                  type_bad;
   logic                  w8, w16, w32, w64;
   logic                  slot_last, completes, out_free, accept;
   logic [AXI_WIDTH-1:0]  beat_data;
   logic [KEEP_WIDTH-1:0] beat_keep;

   // Unsupported widths fall back to 64-bit packing so data keeps moving.
   always_comb begin
      type_bad = !(actual_type_data inside {8'd8, 8'd16, 8'd32, 8'd64})
                 || (actual_type_data < MIN_W);
      w8  = !type_bad && (actual_type_data == 8'd8);
      w16 = !type_bad && (actual_type_data == 8'd16);
      w32 = !type_bad && (actual_type_data == 8'd32);
      w64 = !(w8 || w16 || w32);
   end

   always_comb begin
      slot_last = 1'b1;
      unique case (1'b1)
         w8:      slot_last = (slot_q == 3'd7);
         w16:     slot_last = (slot_q == 3'd3);
         w32:     slot_last = (slot_q == 3'd1);
         w64:     slot_last = 1'b1;
         default: slot_last = 1'b1;
      endcase
   end

   assign completes         = slot_last || in_last;
   assign out_free          = !out_tvalid_q || out_tready;
   assign in_ready          = actual_type_valid && (!completes || out_free);
   assign accept            = in_valid && in_ready;
   assign actual_type_ready = accept && in_last;

   always_comb begin
      beat_data = '0;
      beat_keep = '0;
      unique case (1'b1)
         w8: begin
            for (int s = 0; s < 8; s++) begin
               for (int i = 0; i < NUM_ELEMENTS; i++) begin
                  if (slot_q == 3'(s)) begin
                     beat_data[(s*NUM_ELEMENTS+i)*8 +: 8] = in_data[i][7:0];
                     beat_keep[s*NUM_ELEMENTS+i] = in_keep[i];
                  end
               end
            end
         end
         w16: begin
            for (int s = 0; s < 4; s++) begin
               for (int i = 0; i < NUM_ELEMENTS; i++) begin
                  if (slot_q == 3'(s)) begin
                     beat_data[(s*NUM_ELEMENTS+i)*16 +: 16] = in_data[i][15:0];
                     beat_keep[(s*NUM_ELEMENTS+i)*2 +: 2] = {2{in_keep[i]}};
                  end
               end
            end
         end
         w32: begin
            for (int s = 0; s < 2; s++) begin
               for (int i = 0; i < NUM_ELEMENTS; i++) begin
                  if (slot_q == 3'(s)) begin
                     beat_data[(s*NUM_ELEMENTS+i)*32 +: 32] = in_data[i][31:0];
                     beat_keep[(s*NUM_ELEMENTS+i)*4 +: 4] = {4{in_keep[i]}};
                  end
               end
            end
         end
         w64: begin
            for (int i = 0; i < NUM_ELEMENTS; i++) begin
               beat_data[i*64 +: 64] = in_data[i];
               beat_keep[i*8 +: 8]   = {8{in_keep[i]}};
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      slot_d       = slot_q;
      fill_data_d  = fill_data_q;
      fill_keep_d  = fill_keep_q;
      out_tdata_d  = out_tdata_q;
      out_tkeep_d  = out_tkeep_q;
      out_tlast_d  = out_tlast_q;
      out_tvalid_d = out_tvalid_q;
      type_error_d = type_error_q || (actual_type_valid && type_bad);
      if (out_tready) begin
         out_tvalid_d = 1'b0;
      end
      if (accept) begin
         if (completes) begin
            out_tdata_d  = fill_data_q | beat_data;
            out_tkeep_d  = fill_keep_q | beat_keep;
            out_tlast_d  = in_last;
            out_tvalid_d = 1'b1;
            fill_data_d  = '0;
            fill_keep_d  = '0;
            slot_d       = 3'd0;
         end else begin
            fill_data_d  = fill_data_q | beat_data;
            fill_keep_d  = fill_keep_q | beat_keep;
            slot_d       = slot_q + 3'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         slot_q       <= '0;
         fill_data_q  <= '0;
         fill_keep_q  <= '0;
         out_tdata_q  <= '0;
         out_tkeep_q  <= '0;
         out_tlast_q  <= 1'b0;
         out_tvalid_q <= 1'b0;
         type_error_q <= 1'b0;
      end else begin
         slot_q       <= slot_d;
         fill_data_q  <= fill_data_d;
         fill_keep_q  <= fill_keep_d;
         out_tdata_q  <= out_tdata_d;
         out_tkeep_q  <= out_tkeep_d;
         out_tlast_q  <= out_tlast_d;
         out_tvalid_q <= out_tvalid_d;
         type_error_q <= type_error_d;
      end
   end

   assign out_tdata  = out_tdata_q;
   assign out_tkeep  = out_tkeep_q;
   assign out_tlast  = out_tlast_q;
   assign out_tvalid = out_tvalid_q;
   assign type_error = type_error_q;

endmodule

// File: tb/tb_ndata_axi_typed_packer.sv
// Bench for ndata_axi_typed_packer: directed and random packets against
// a byte-placement reference model with an expected-beat queue.
module tb_ndata_axi_typed_packer;

   localparam int N    = 8;
   localparam int AW   = 64 * N;
   localparam int KW   = AW / 8;
   localparam int MINW = 8;

   typedef struct {
      logic [AW-1:0] d;
      logic [KW-1:0] k;
      logic          l;
   } beat_t;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [7:0]           actual_type_data;
   logic                 actual_type_valid;
   logic                 actual_type_ready;
   logic [N-1:0][63:0]   in_data;
   logic [N-1:0]         in_keep;
   logic                 in_last;
   logic                 in_valid;
   logic                 in_ready;
   logic [AW-1:0]        out_tdata;
   logic [KW-1:0]        out_tkeep;
   logic                 out_tlast;
   logic                 out_tvalid;
   logic                 out_tready;
   logic                 type_error;

   int            tests = 0;
   int            fails = 0;
   beat_t         exp_q[$];
   int            chunk_n;
   logic [AW-1:0] acc_d;
   logic [KW-1:0] acc_k;
   logic          exp_te;
   bit            got_acc;
   bit            rand_ready;
   bit            stall_arm;
   int            stall_left;
   int            type_pulses;

   ndata_axi_typed_packer #(
      .NUM_ELEMENTS  (N),
      .MIN_TYPE_WIDTH(MINW)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .actual_type_data (actual_type_data),
      .actual_type_valid(actual_type_valid),
      .actual_type_ready(actual_type_ready),
      .in_data          (in_data),
      .in_keep          (in_keep),
      .in_last          (in_last),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .out_tdata        (out_tdata),
      .out_tkeep        (out_tkeep),
      .out_tlast        (out_tlast),
      .out_tvalid       (out_tvalid),
      .out_tready       (out_tready),
      .type_error       (type_error)
   );

   always #5 clk = ~clk;

   function automatic bit bad_w(int w);
      return !(w == 8 || w == 16 || w == 32 || w == 64) || (w < MINW);
   endfunction

   function automatic int eff_w(int w);
      return bad_w(w) ? 64 : w;
   endfunction

   task automatic chk(string tag, logic [AW-1:0] obs, logic [AW-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      exp_q.delete();
      chunk_n = 0;
      acc_d   = '0;
      acc_k   = '0;
      exp_te  = 1'b0;
   endtask

   // One clock: choose tready, sample at negedge, check, advance model.
   task automatic cycle();
      int          ew;
      int          r;
      bit          comp;
      bit          rdy;
      bit          acc;
      logic [63:0] e;
      if (stall_left > 0) begin
         out_tready = 1'b0;
         stall_left--;
      end else begin
         out_tready = rand_ready ? 1'($urandom_range(1)) : 1'b1;
      end
      got_acc = 1'b0;
      @(negedge clk);
      if (rst) begin
         model_clear();
      end else begin
         ew   = eff_w(int'(actual_type_data));
         r    = 64 / ew;
         comp = (chunk_n + 1 == r) || in_last;
         rdy  = actual_type_valid
                && (!comp || exp_q.size() == 0 || out_tready);
         acc  = in_valid && rdy;
         chk("in_ready", AW'(in_ready), AW'(rdy));
         chk("type_ready", AW'(actual_type_ready), AW'(acc && in_last));
         chk("tvalid", AW'(out_tvalid), AW'(exp_q.size() != 0));
         chk("type_error", AW'(type_error), AW'(exp_te));
         if (exp_q.size() != 0) begin
            chk("tdata", out_tdata, exp_q[0].d);
            chk("tkeep", AW'(out_tkeep), AW'(exp_q[0].k));
            chk("tlast", AW'(out_tlast), AW'(exp_q[0].l));
            if (out_tready) void'(exp_q.pop_front());
         end
         if (acc) begin
            got_acc = 1'b1;
            if (in_last) type_pulses++;
            for (int i = 0; i < N; i++) begin
               e = (ew == 64) ? in_data[i]
                              : in_data[i] & ((64'd1 << ew) - 64'd1);
               acc_d |= {{(AW-64){1'b0}}, e} << ((chunk_n*N + i) * ew);
               for (int b = 0; b < ew / 8; b++)
                  acc_k[(chunk_n*N + i)*(ew/8) + b] = in_keep[i];
            end
            if (comp) begin
               exp_q.push_back('{d: acc_d, k: acc_k, l: in_last});
               acc_d   = '0;
               acc_k   = '0;
               chunk_n = 0;
               if (stall_arm) begin
                  stall_left = 10;
                  stall_arm  = 1'b0;
               end
            end else begin
               chunk_n++;
            end
         end
         if (actual_type_valid && bad_w(int'(actual_type_data)))
            exp_te = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_pkt(int w, int nb, bit with_last, bit seq,
                           int vprob, bit rkeep);
      int n;
      actual_type_data  = 8'(w);
      actual_type_valid = 1'b1;
      for (int b = 0; b < nb; b++) begin
         for (int i = 0; i < N; i++)
            in_data[i] = seq ? 64'(b*N + i) : {$urandom, $urandom};
         in_keep = rkeep ? N'($urandom) : '1;
         in_last = with_last && (b == nb - 1);
         n = 0;
         do begin
            in_valid = ($urandom_range(99) < vprob);
            cycle();
            n++;
         end while (!got_acc && n < 300);
         tests++;
         assert (got_acc) else begin
            fails++;
            $error("FAIL accept_timeout: observed %0d cycles expected <300", n);
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   initial begin
      rst               = 1'b1;
      actual_type_data  = 8'd64;
      actual_type_valid = 1'b0;
      in_data           = '0;
      in_keep           = '0;
      in_last           = 1'b0;
      in_valid          = 1'b0;
      out_tready        = 1'b1;
      rand_ready        = 1'b0;
      stall_arm         = 1'b0;
      stall_left        = 0;
      type_pulses       = 0;
      model_clear();
      @(posedge clk);
      #1;
      cycle();
      cycle();
      rst = 1'b0;
      chk("rst_tvalid", AW'(out_tvalid), '0);
      chk("rst_tdata", out_tdata, '0);
      chk("rst_tkeep", AW'(out_tkeep), '0);
      chk("rst_tlast", AW'(out_tlast), '0);
      chk("rst_type_error", AW'(type_error), '0);

      send_pkt(64, 3, 1, 0, 100, 0);
      cycle();

      type_pulses = 0;
      send_pkt(32, 4, 1, 1, 100, 0);
      chk("type_pulses32", AW'(type_pulses), AW'(1));
      cycle();

      send_pkt(8, 3, 1, 0, 100, 0);
      cycle();

      stall_arm = 1'b1;
      send_pkt(16, 8, 1, 0, 100, 1);
      repeat (3) cycle();

      send_pkt(32, 3, 1, 0, 100, 1);
      send_pkt(64, 2, 1, 0, 100, 1);
      cycle();

      send_pkt(4, 2, 1, 0, 100, 1);
      send_pkt(16, 5, 1, 0, 100, 1);
      repeat (2) cycle();
      chk("type_error_sticky", AW'(type_error), AW'(1));

      actual_type_data = 8'd8;
      stall_arm = 1'b1;
      send_pkt(8, 10, 0, 0, 100, 1);
      rst = 1'b1;
      cycle();
      rst        = 1'b0;
      stall_left = 0;
      stall_arm  = 1'b0;
      chk("mid_rst_tvalid", AW'(out_tvalid), '0);
      chk("mid_rst_tdata", out_tdata, '0);
      chk("mid_rst_tkeep", AW'(out_tkeep), '0);
      chk("mid_rst_tlast", AW'(out_tlast), '0);
      chk("mid_rst_type_error", AW'(type_error), '0);
      send_pkt(8, 3, 1, 0, 100, 0);
      repeat (2) cycle();

      rand_ready = 1'b1;
      for (int p = 0; p < 30; p++) begin
         int ws;
         ws = 8 << $urandom_range(3);
         if ($urandom_range(3) == 0) begin
            actual_type_valid = 1'b0;
            cycle();
         end
         send_pkt(ws, 1 + $urandom_range(9), 1, 0, 70, 1);
      end

      rand_ready = 1'b0;
      repeat (5) cycle();
      chk("drain_empty", AW'(exp_q.size()), '0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
